weight_skew_fifo: RTL and testbench
===================================

Name: weight_skew_fifo

Overview:
- Parametrised weight staging buffer that feeds the systolic array's weight inputs. It replaces the fixed 16x16 weight FIFO plus separate stagger controller.
- Loads rows of NUM_COLS weights from memArr read data through a valid/ready handshake.
- On start, drains them either aligned or diagonally skewed (column c delayed c cycles). Drain count equals the rows held at start.

Parameters:
- NUM_COLS, 16, number of array columns (weight lanes); >=2
- DATA_WIDTH, 8, bits per weight
- DEPTH, 16, row capacity; power of two, >=2

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk
- wr_valid  input  1  wr_data holds a valid row
- wr_ready  output  1  buffer can accept a row this cycle
- wr_data  input  NUM_COLS*DATA_WIDTH  row; column c = bits [c*DATA_WIDTH +: DATA_WIDTH]
- start  input  1  single-cycle request to drain; honoured only in IDLE
- stagger  input  1  sampled with start: 1 = skewed drain, 0 = aligned
- rd_data  output  NUM_COLS*DATA_WIDTH  registered weight row to the array
- col_valid  output  NUM_COLS  per-column valid for rd_data
- count  output  $clog2(DEPTH)+1  rows currently stored
- busy  output  1  high in DRAIN
- done  output  1  one-cycle pulse at end of drain

Behaviour:
- Reset values: wr_ready=1, rd_data=0, col_valid=0, count=0, busy=0, done=0. Write/read pointers=0, FSM=IDLE.
- Storage: circular buffer of DEPTH rows; pointers wrap modulo DEPTH.
- FSM has three states: IDLE, DRAIN, FIN.
- IDLE:
  - wr_ready = (count != DEPTH).
  - A write occurs on wr_valid & wr_ready: row stored at wr_ptr, wr_ptr+1, count+1.
  - wr_valid while full is ignored; no overwrite, no error.
  - start with count==0 goes to FIN directly; no output cycles.
  - start with count=N>0 latches N and stagger, clears step counter k=0, and goes to DRAIN.
  - start and a write in the same cycle: the write is accepted and included in N.
- DRAIN:
  - wr_ready=0 and busy=1.
  - Registered output: for drain cycle k, col_valid[c] and rd_data col c update at the clock edge ending cycle k, so they are visible one cycle later.
  - First valid output appears the cycle after the first DRAIN cycle.
  - Aligned: lane c emits row (rd_base+k) for 0<=k<N. Drain length L=N.
  - Skewed: lane c emits row (rd_base+k-c) when 0<=k-c<N. L=N+NUM_COLS-1.
  - Inactive lanes drive 0 with col_valid[c]=0.
  - At k=L-1, go to FIN. Consumed rows are popped at transition: rd_ptr+=N, count-=N (without REPLAY).
  - start during DRAIN is ignored.
- FIN:
  - Lasts one cycle; done=1 and col_valid/rd_data return to 0. Returns to IDLE.
  - wr_ready returns the cycle after FIN.
- Reset mid-drain aborts immediately: all state and outputs go to reset values and stored rows are discarded.
- No arithmetic on data; widths pass through unchanged.

Optional Feature:
- Macro: WEIGHT_SKEW_FIFO_REPLAY_EN.
- Defined:
  - Adds input port keep (1 bit), sampled with start.
  - keep=1: drain does not pop; rd_ptr and count are unchanged, so the next start replays the same N rows (array re-use across tiles).
  - keep=0: normal pop.
  - While rows are kept, writes still append up to DEPTH.
- Undefined: no keep port; every drain pops N rows.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release -> wr_ready=1, count=0, col_valid=0, rd_data=0. Pull reset low mid-drain -> same values next sample.
- Aligned drain, defaults: write 4 rows with row r lane c = r*16+c+1, then start, stagger=0 -> col_valid=16'hFFFF for exactly 4 cycles, rows in order 0..3, then done pulses once and count=0.
- Skewed drain: write 16 rows {1..16} pattern, then start, stagger=1 -> 31 drain cycles. Lane 0 is valid on cycles 0..15, lane 15 on cycles 15..30. Cycle 15 shows all lanes valid. done follows cycle 30.
- Full/wrap: write 16 rows -> wr_ready=0 and a 17th wr_valid is ignored (count=16). Drain 16, write 3 more, drain aligned -> the 3 rows come out correctly across pointer wrap.
- Edge cases: start with count=0 -> done pulse next cycle, col_valid never set. start+write same cycle with count=2 -> N=3. start during DRAIN has no effect.
- With WEIGHT_SKEW_FIFO_REPLAY_EN: write 2 rows, start keep=1 -> count stays 2. A second start replays identical data. A third start with keep=0 -> count=0.

Source files
------------

// File: rtl/weight_skew_fifo.sv
// Weight staging buffer for the systolic array: loads rows via valid/ready and
// drains them aligned or diagonally skewed. Define WEIGHT_SKEW_FIFO_REPLAY_EN to add the keep/replay input.
module weight_skew_fifo #(
  parameter int unsigned NUM_COLS   = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] wr_data,
  input  logic                           start,
  input  logic                           stagger,
`ifdef WEIGHT_SKEW_FIFO_REPLAY_EN
  input  logic                           keep,
`endif
  output logic [NUM_COLS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_COLS-1:0]            col_valid,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned ROW_W = NUM_COLS * DATA_WIDTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned K_W   = $clog2(DEPTH + NUM_COLS);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d, n_q, n_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               stagger_q, stagger_d, keep_q, keep_d;
  logic [ROW_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_COLS-1:0] col_valid_q, col_valid_d;
  logic               wr_ready_q, wr_ready_d, busy_q, busy_d, done_q, done_d;
  logic               wr_en, keep_s, lane_act;
  logic [K_W-1:0]     last_k, lane_off;
  logic [PTR_W-1:0]   lane_row;
  logic [ROW_W-1:0]   mem_q [DEPTH];

`ifdef WEIGHT_SKEW_FIFO_REPLAY_EN
  assign keep_s = keep;
`else
  assign keep_s = 1'b0;
`endif

  // Final step index of the drain: N-1 aligned, N+NUM_COLS-2 skewed.
  assign last_k = stagger_q ? K_W'(n_q) + K_W'(NUM_COLS - 1) - K_W'(1)
                            : K_W'(n_q) - K_W'(1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    n_d         = n_q;
    k_d         = k_q;
    stagger_d   = stagger_q;
    keep_d      = keep_q;
    rd_data_d   = '0;
    col_valid_d = '0;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    lane_act    = 1'b0;
    lane_off    = '0;
    lane_row    = '0;
    unique case (state_q)
      S_IDLE: begin
        wr_en = wr_valid & wr_ready_q;
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
        // A same-cycle write is counted into N.
        if (start) begin
          if (count_d == '0) begin
            state_d = S_FIN;
          end else begin
            n_d       = count_d;
            stagger_d = stagger;
            keep_d    = keep_s;
            k_d       = '0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (stagger_q) begin
            lane_off = k_q - K_W'(c);
            lane_act = (k_q >= K_W'(c)) && (lane_off < K_W'(n_q));
          end else begin
            lane_off = k_q;
            lane_act = k_q < K_W'(n_q);
          end
          lane_row = rd_ptr_q + PTR_W'(lane_off);
          if (lane_act) begin
            rd_data_d[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[lane_row][c*DATA_WIDTH +: DATA_WIDTH];
            col_valid_d[c] = 1'b1;
          end
        end
        k_d = k_q + K_W'(1);
        if (k_q == last_k) begin
          state_d = S_FIN;
          if (!keep_q) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(n_q);
            count_d  = count_q - n_q;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wr_ready_d = (state_d == S_IDLE) && (count_d != CNT_W'(DEPTH));
    busy_d     = (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      n_q         <= '0;
      k_q         <= '0;
      stagger_q   <= 1'b0;
      keep_q      <= 1'b0;
      rd_data_q   <= '0;
      col_valid_q <= '0;
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      n_q         <= n_d;
      k_q         <= k_d;
      stagger_q   <= stagger_d;
      keep_q      <= keep_d;
      rd_data_q   <= rd_data_d;
      col_valid_q <= col_valid_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Row storage needs no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign col_valid = col_valid_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_weight_skew_fifo.sv
// Directed bench for weight_skew_fifo (16 lanes x 8 bits, depth 16).
module tb_weight_skew_fifo;

  localparam int NC = 16;
  localparam int DW = 8;
  localparam int DP = 16;
  localparam int RW = NC * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [RW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          stagger = 1'b0;
`ifdef WEIGHT_SKEW_FIFO_REPLAY_EN
  logic          keep = 1'b0;
`endif
  logic [RW-1:0] rd_data;
  logic [NC-1:0] col_valid;
  logic [4:0]    count;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  weight_skew_fifo #(.NUM_COLS(NC), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .start     (start),
    .stagger   (stagger),
`ifdef WEIGHT_SKEW_FIFO_REPLAY_EN
    .keep      (keep),
`endif
    .rd_data   (rd_data),
    .col_valid (col_valid),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Row r, lane c carries r*16+c+1 (mod 256).
  function automatic logic [RW-1:0] make_row(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = 8'(r * 16 + c + 1);
    return v;
  endfunction

  task automatic write_row(input int r);
    wr_valid = 1'b1;
    wr_data  = make_row(r);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Starts a drain of n rows (logical ids base..) and checks every output cycle.
  // wr_row >= 0 adds a same-cycle write; poke asserts start again mid-drain.
  task automatic drain(input int n, input bit stag, input bit kp, input int base,
                       input int wr_row, input bit poke, input int exp_cnt);
    int len;
    logic [RW-1:0] exp_rd;
    logic [NC-1:0] exp_cv;
    len = stag ? n + NC - 1 : n;
    if (wr_row >= 0) begin
      wr_valid = 1'b1;
      wr_data  = make_row(wr_row);
    end
    start   = 1'b1;
    stagger = stag;
`ifdef WEIGHT_SKEW_FIFO_REPLAY_EN
    keep = kp;
`endif
    @(negedge clk);
    start    = 1'b0;
    wr_valid = 1'b0;
    chk("busy_first", RW'(busy), RW'(1));
    chk("wr_ready_drain", RW'(wr_ready), RW'(0));
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      start  = 1'b0;
      exp_rd = '0;
      exp_cv = '0;
      for (int c = 0; c < NC; c++) begin
        int j;
        j = stag ? k - c : k;
        if (j >= 0 && j < n) begin
          exp_cv[c] = 1'b1;
          exp_rd[c*DW +: DW] = 8'((base + j) * 16 + c + 1);
        end
      end
      chk($sformatf("col_valid k=%0d", k), RW'(col_valid), RW'(exp_cv));
      chk($sformatf("rd_data k=%0d", k), rd_data, exp_rd);
      chk($sformatf("busy k=%0d", k), RW'(busy), RW'(k + 1 < len));
      chk($sformatf("done_early k=%0d", k), RW'(done), RW'(0));
      if (poke && k == 0) start = 1'b1;
    end
    @(negedge clk);
    chk("done_pulse", RW'(done), RW'(1));
    chk("col_valid_fin", RW'(col_valid), RW'(0));
    chk("rd_data_fin", rd_data, RW'(0));
    chk("busy_fin", RW'(busy), RW'(0));
    chk("count_after", RW'(count), RW'(exp_cnt));
    chk("wr_ready_after", RW'(wr_ready), RW'(exp_cnt != DP));
    @(negedge clk);
    chk("done_single", RW'(done), RW'(0));
    chk("col_valid_idle", RW'(col_valid), RW'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_ready"}, RW'(wr_ready), RW'(1));
    chk({tag, "_count"}, RW'(count), RW'(0));
    chk({tag, "_col_valid"}, RW'(col_valid), RW'(0));
    chk({tag, "_rd_data"}, rd_data, RW'(0));
    chk({tag, "_busy"}, RW'(busy), RW'(0));
    chk({tag, "_done"}, RW'(done), RW'(0));
  endtask

  initial begin
    // Reset held two cycles, released away from the active edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");

    // Aligned drain of 4 rows.
    for (int r = 0; r < 4; r++) write_row(r);
    chk("count_4", RW'(count), RW'(4));
    drain(4, 1'b0, 1'b0, 0, -1, 1'b0, 0);

    // Fill to 16 (pointers start at 4, so storage wraps); 17th write ignored.
    for (int r = 0; r < 16; r++) write_row(r);
    chk("count_full", RW'(count), RW'(16));
    chk("wr_ready_full", RW'(wr_ready), RW'(0));
    write_row(99);
    chk("count_ignored", RW'(count), RW'(16));
    drain(16, 1'b1, 1'b0, 0, -1, 1'b0, 0);

    // Three more rows, aligned drain.
    for (int r = 20; r < 23; r++) write_row(r);
    chk("count_3", RW'(count), RW'(3));
    drain(3, 1'b0, 1'b0, 20, -1, 1'b0, 0);

    // Start with an empty buffer: FIN only, done one cycle after FIN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_busy", RW'(busy), RW'(0));
    chk("empty_cv_fin", RW'(col_valid), RW'(0));
    chk("empty_done_fin", RW'(done), RW'(0));
    @(negedge clk);
    chk("empty_done", RW'(done), RW'(1));
    chk("empty_cv", RW'(col_valid), RW'(0));
    @(negedge clk);
    chk("empty_done_single", RW'(done), RW'(0));

    // Start together with a write at count 2 gives N=3; start mid-drain ignored.
    write_row(30);
    write_row(31);
    drain(3, 1'b0, 1'b0, 30, 32, 1'b1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_redrain_cv", RW'(col_valid), RW'(0));
      chk("no_redrain_busy", RW'(busy), RW'(0));
    end

`ifdef WEIGHT_SKEW_FIFO_REPLAY_EN
    // Kept rows replay; a final non-keep drain pops them.
    write_row(50);
    write_row(51);
    drain(2, 1'b0, 1'b1, 50, -1, 1'b0, 2);
    drain(2, 1'b1, 1'b1, 50, -1, 1'b0, 2);
    drain(2, 1'b0, 1'b0, 50, -1, 1'b0, 0);
`endif

    // Reset mid-drain aborts and discards stored rows.
    write_row(40);
    write_row(41);
    start = 1'b1;
    stagger = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_abort_cv", RW'(col_valid), RW'(16'h0001));
    reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
